// File: rtl/complex_conj_pipe_if.sv
// ============================================================================
// Module   : complex_conj_pipe_if
// Purpose  : Streaming bus for complex_conj_pipe (input and output handshakes).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface complex_conj_pipe_if #(
  parameter int FW = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2*FW-1:0]   in_data;
  logic [2:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [2*FW-1:0]   out_data;
  logic              out_nan;
  logic              out_mode_err;
  logic [15:0]       sample_cnt;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_nan, out_mode_err, sample_cnt
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_nan, out_mode_err, sample_cnt
  );
endinterface

`default_nettype wire

// File: rtl/complex_conj_pipe.sv
// ============================================================================
// Module   : complex_conj_pipe
// Purpose  : Elastic pipeline applying sign/rotation ops to packed complex floats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module complex_conj_pipe #(
  parameter int FW         = 32,
  parameter int EW         = 8,
  parameter int STAGES     = 2,
  parameter int ZERO_CANON = 0
) (
  input  logic                clk,
  input  logic                rst,
  complex_conj_pipe_if.slave  bus
);
  localparam int MW = FW - 1 - EW;
  localparam int PW = 2*FW + 2;

  localparam logic [2:0] c_mode_pass = 3'd0;
  localparam logic [2:0] c_mode_conj = 3'd1;
  localparam logic [2:0] c_mode_neg  = 3'd2;
  localparam logic [2:0] c_mode_mulj = 3'd3;
  localparam logic [2:0] c_mode_muln = 3'd4;
  localparam logic [2:0] c_mode_swap = 3'd5;

  function automatic logic is_nan(input logic [FW-1:0] x);
    return (&x[FW-2:MW]) && (|x[MW-1:0]);
  endfunction

  // NaN operands keep their sign so payloads pass through bit-exact.
  function automatic logic [FW-1:0] neg(input logic [FW-1:0] x);
    return is_nan(x) ? x : {~x[FW-1], x[FW-2:0]};
  endfunction

  function automatic logic [FW-1:0] canon(input logic [FW-1:0] x);
    if ((ZERO_CANON != 0) && (x == {1'b1, {(FW-1){1'b0}}}))
      return '0;
    return x;
  endfunction

  // Stage 0: raw operand register
  logic              s0_valid_q, s0_valid_d;
  logic [2*FW-1:0]   s0_data_q;
  logic [2:0]        s0_mode_q;
  logic              w_s0_load;
  logic              w_s0_next_rdy;

  assign w_s0_load   = !s0_valid_q || w_s0_next_rdy;
  assign bus.in_ready = !rst && w_s0_load;
  assign s0_valid_d  = bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
      s0_mode_q  <= '0;
    end else if (w_s0_load) begin
      s0_valid_q <= s0_valid_d;
      if (bus.in_valid) begin
        s0_data_q <= bus.in_data;
        s0_mode_q <= bus.in_mode;
      end
    end
  end

  // Operation on the stage-0 operands
  logic [FW-1:0] w_re, w_im, w_op_re, w_op_im, w_res_re, w_res_im;
  logic          w_err;
  logic [PW-1:0] w_res;

  always_comb begin
    w_re    = s0_data_q[2*FW-1:FW];
    w_im    = s0_data_q[FW-1:0];
    w_op_re = w_re;
    w_op_im = w_im;
    w_err   = 1'b0;
    case (s0_mode_q)
      c_mode_pass: ;
      c_mode_conj: w_op_im = neg(w_im);
      c_mode_neg: begin
        w_op_re = neg(w_re);
        w_op_im = neg(w_im);
      end
      c_mode_mulj: begin
        w_op_re = neg(w_im);
        w_op_im = w_re;
      end
      c_mode_muln: begin
        w_op_re = w_im;
        w_op_im = neg(w_re);
      end
      c_mode_swap: begin
        w_op_re = w_im;
        w_op_im = w_re;
      end
      default: w_err = 1'b1;
    endcase
    w_res_re = canon(w_op_re);
    w_res_im = canon(w_op_im);
    w_res    = {is_nan(w_res_re) | is_nan(w_res_im), w_err, w_res_re, w_res_im};
  end

  generate
    if (STAGES <= 1) begin : g_single
      assign w_s0_next_rdy    = bus.out_ready;
      assign bus.out_valid    = s0_valid_q;
      assign bus.out_data     = w_res[2*FW-1:0];
      assign bus.out_mode_err = w_res[2*FW];
      assign bus.out_nan      = w_res[2*FW+1];
    end else begin : g_multi
      localparam int ND = STAGES - 1;
      logic [ND-1:0] dv_q;
      logic [PW-1:0] dp_q [ND];
      logic [ND-1:0] w_load;

      // A stage may load if any stage from it to the output has a hole, or the output drains.
      always_comb begin
        w_load = '0;
        for (int j = 0; j < ND; j++) begin
          w_load[j] = bus.out_ready;
          for (int k = j; k < ND; k++)
            if (!dv_q[k]) w_load[j] = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dv_q <= '0;
          for (int j = 0; j < ND; j++) dp_q[j] <= '0;
        end else begin
          if (w_load[0]) begin
            dv_q[0] <= s0_valid_q;
            if (s0_valid_q) dp_q[0] <= w_res;
          end
          for (int j = 1; j < ND; j++) begin
            if (w_load[j]) begin
              dv_q[j] <= dv_q[j-1];
              if (dv_q[j-1]) dp_q[j] <= dp_q[j-1];
            end
          end
        end
      end

      assign w_s0_next_rdy    = w_load[0];
      assign bus.out_valid    = dv_q[ND-1];
      assign bus.out_data     = dp_q[ND-1][2*FW-1:0];
      assign bus.out_mode_err = dp_q[ND-1][2*FW];
      assign bus.out_nan      = dp_q[ND-1][2*FW+1];
    end
  endgenerate

  logic [15:0] cnt_q, cnt_d;
  logic        w_xfer;

  assign w_xfer         = bus.out_valid && bus.out_ready;
  assign cnt_d          = cnt_q + 16'd1;
  assign bus.sample_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (w_xfer) cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_complex_conj_pipe.sv
// ============================================================================
// Module   : tb_complex_conj_pipe
// Purpose  : Directed self-checking bench for complex_conj_pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_complex_conj_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  complex_conj_pipe_if #(.FW(32)) bus0 ();
  complex_conj_pipe_if #(.FW(32)) bus1 ();

  complex_conj_pipe #(.FW(32), .EW(8), .STAGES(2), .ZERO_CANON(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  complex_conj_pipe #(.FW(32), .EW(8), .STAGES(2), .ZERO_CANON(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // The canonicalising instance sees identical stimulus
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_data   = bus0.in_data;
  assign bus1.in_mode   = bus0.in_mode;
  assign bus1.out_ready = bus0.out_ready;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic [63:0] d, input logic [2:0] m,
                      input logic [63:0] exp_d, input logic exp_nan, input logic exp_err,
                      input logic [63:0] exp_d1);
    int n;
    @(negedge clk);
    bus0.in_valid  = 1'b1;
    bus0.in_data   = d;
    bus0.in_mode   = m;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    n = 0;
    while (!bus0.out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.out_valid) begin
      chk({tag, "_timeout"}, 64'(bus0.out_valid), 64'd1);
    end else begin
      chk({tag, "_data"}, bus0.out_data, exp_d);
      chk({tag, "_nan"}, 64'(bus0.out_nan), 64'(exp_nan));
      chk({tag, "_err"}, 64'(bus0.out_mode_err), 64'(exp_err));
      chk({tag, "_zc"}, bus1.out_data, exp_d1);
    end
  endtask

  logic [63:0] bp_in  [3];
  logic [2:0]  bp_mode[3];
  logic [63:0] bp_exp [3];

  initial begin
    int nrecv, first, last, sent, got, seen;
    logic [31:0] sre, sim;

    rst = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.in_data   = '0;
    bus0.in_mode   = '0;
    bus0.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus0.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_out_data", bus0.out_data, 64'd0);
    chk("rst_out_nan", 64'(bus0.out_nan), 64'd0);
    chk("rst_out_err", 64'(bus0.out_mode_err), 64'd0);
    chk("rst_cnt", 64'(bus0.sample_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 64'(bus0.in_ready), 64'd1);

    // Latency: presented in cycle c, visible in cycle c+2
    @(negedge clk);
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 64'h3F800000_40000000;
    bus0.in_mode   = 3'd1;
    bus0.out_ready = 1'b1;
    #1;
    chk("lat_accept", 64'(bus0.in_ready), 64'd1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    chk("lat_c1_valid", 64'(bus0.out_valid), 64'd0);
    @(negedge clk);
    chk("lat_c2_valid", 64'(bus0.out_valid), 64'd1);
    chk("lat_c2_data", bus0.out_data, 64'h3F800000_C0000000);
    @(negedge clk);
    chk("lat_c3_valid", 64'(bus0.out_valid), 64'd0);
    chk("lat_cnt", 64'(bus0.sample_cnt), 64'd1);

    xfer("mulj",  64'h3F800000_40000000, 3'd3, 64'hC0000000_3F800000, 1'b0, 1'b0, 64'hC0000000_3F800000);
    xfer("muln",  64'h3F800000_40000000, 3'd4, 64'h40000000_BF800000, 1'b0, 1'b0, 64'h40000000_BF800000);
    xfer("swap",  64'h3F800000_40000000, 3'd5, 64'h40000000_3F800000, 1'b0, 1'b0, 64'h40000000_3F800000);
    xfer("neginf",64'hFF800000_00000000, 3'd2, 64'h7F800000_80000000, 1'b0, 1'b0, 64'h7F800000_00000000);
    xfer("negnan",64'h7FC00000_00000000, 3'd2, 64'h7FC00000_80000000, 1'b1, 1'b0, 64'h7FC00000_00000000);
    xfer("conjnan",64'h3F800000_FFC00001, 3'd1, 64'h3F800000_FFC00001, 1'b1, 1'b0, 64'h3F800000_FFC00001);
    xfer("negden",64'h80000000_00000001, 3'd2, 64'h00000000_80000001, 1'b0, 1'b0, 64'h00000000_80000001);
    xfer("mulj0", 64'h00000000_00000000, 3'd3, 64'h80000000_00000000, 1'b0, 1'b0, 64'h00000000_00000000);
    xfer("pass",  64'h3F800000_40000000, 3'd0, 64'h3F800000_40000000, 1'b0, 1'b0, 64'h3F800000_40000000);
    xfer("rsv7",  64'h3F800000_40000000, 3'd7, 64'h3F800000_40000000, 1'b0, 1'b1, 64'h3F800000_40000000);
    xfer("rsv6",  64'hFF800000_80000000, 3'd6, 64'hFF800000_80000000, 1'b0, 1'b1, 64'hFF800000_00000000);
    xfer("after_rsv", 64'h3F800000_40000000, 3'd1, 64'h3F800000_C0000000, 1'b0, 1'b0, 64'h3F800000_C0000000);

    // Back-to-back burst of 8 conj samples
    do_reset();
    nrecv = 0; first = -1; last = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus0.out_valid) begin
        sre = 32'h3F800000 + 32'(nrecv);
        sim = 32'hC0000000 + 32'(nrecv);
        chk("burst_data", bus0.out_data, {sre, sim});
        if (first < 0) first = k;
        last = k;
        nrecv++;
      end
      bus0.in_valid = (k < 8);
      bus0.in_data  = {32'h3F800000 + 32'(k), 32'h40000000 + 32'(k)};
      bus0.in_mode  = 3'd1;
    end
    chk("burst_count", 64'(nrecv), 64'd8);
    chk("burst_first", 64'(first), 64'd2);
    chk("burst_span", 64'(last - first), 64'd7);
    chk("burst_cnt", 64'(bus0.sample_cnt), 64'd8);

    // Backpressure: out_ready low for 5 cycles with A, B, C offered
    bp_in[0] = 64'h3F800000_40000000; bp_mode[0] = 3'd0; bp_exp[0] = 64'h3F800000_40000000;
    bp_in[1] = 64'h3F800000_40000000; bp_mode[1] = 3'd1; bp_exp[1] = 64'h3F800000_C0000000;
    bp_in[2] = 64'h3F800000_40000000; bp_mode[2] = 3'd2; bp_exp[2] = 64'hBF800000_C0000000;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      @(negedge clk);
      bus0.out_ready = (cyc >= 5);
      bus0.in_valid  = (sent < 3);
      if (sent < 3) begin
        bus0.in_data = bp_in[sent];
        bus0.in_mode = bp_mode[sent];
      end
      #1;
      if (cyc == 4) begin
        chk("bp_accepted", 64'(sent), 64'd2);
        chk("bp_in_ready_low", 64'(bus0.in_ready), 64'd0);
      end
      if (bus0.out_valid) begin
        chk(bus0.out_ready ? "bp_order" : "bp_hold", bus0.out_data, bp_exp[got]);
        if (bus0.out_ready) got++;
      end
      if (bus0.in_valid && bus0.in_ready) sent++;
    end
    chk("bp_delivered", 64'(got), 64'd3);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus0.out_valid) seen++;
    end
    chk("bp_no_dup", 64'(seen), 64'd0);
    chk("bp_cnt", 64'(bus0.sample_cnt), 64'd11);

    // Reset with a full, stalled pipeline
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 64'h3F800000_40000000;
    bus0.in_mode   = 3'd0;
    repeat (2) @(negedge clk);
    bus0.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_valid", 64'(bus0.out_valid), 64'd0);
    chk("rmid_cnt", 64'(bus0.sample_cnt), 64'd0);
    chk("rmid_in_ready", 64'(bus0.in_ready), 64'd0);
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    #1;
    chk("rmid_release_ready", 64'(bus0.in_ready), 64'd1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus0.out_valid) seen++;
    end
    chk("rmid_no_stale", 64'(seen), 64'd0);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      bus0.in_valid = 1'b1;
      bus0.in_data  = 64'(i);
      bus0.in_mode  = 3'd0;
    end
    @(negedge clk);
    bus0.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrap_pre", 64'(bus0.sample_cnt), 64'hFFFF);
    xfer("wrap_last", 64'h3F800000_40000000, 3'd0, 64'h3F800000_40000000, 1'b0, 1'b0, 64'h3F800000_40000000);
    @(negedge clk);
    chk("wrap_zero", 64'(bus0.sample_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
